// File: rtl/debug_run_ctrl_pkg.sv
// Shared encodings for the debugger run controller.
// Optional breakpoint stop is enabled with DEBUG_BREAKPOINT_EN.
package debug_pkg;

    typedef enum logic [2:0] {
        RUN_IDLE      = 3'd0,
        RUN_RUN       = 3'd1,
        RUN_STEP_WAIT = 3'd2,
        RUN_SEND      = 3'd3,
        RUN_WAIT_SEND = 3'd4,
        RUN_DONE      = 3'd5
    } run_state_e;

    localparam logic [1:0] MODE_CONT  = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_NSTEP = 2'b10;

    localparam int unsigned TIMEOUT_DEFAULT = 1048576;

endpackage

// File: rtl/debug_run_ctrl_if.sv
// Command/pipeline/sender bundle for the run controller.
// Breakpoint signals exist only with DEBUG_BREAKPOINT_EN.
interface debug_run_ctrl_if #(
    parameter int unsigned CLK_CNT_W  = 32,
    parameter int unsigned STEP_CNT_W = 16
`ifdef DEBUG_BREAKPOINT_EN
    , parameter int unsigned PC_W = 32
`endif
);
    logic                  is_start;
    logic [1:0]            i_mode;
    logic [STEP_CNT_W-1:0] i_step_count;
    logic                  is_step_req;
    logic                  is_stop_pipe;
    logic                  is_done_send;
    logic                  is_abort;
    logic                  os_step;
    logic                  os_start_send;
    logic                  os_done;
    logic [CLK_CNT_W-1:0]  o_clk_count;
    logic                  o_busy;
    logic                  o_timeout;
    logic [2:0]            o_state;
`ifdef DEBUG_BREAKPOINT_EN
    logic [PC_W-1:0]       i_pc;
    logic [PC_W-1:0]       i_bp_addr;
    logic                  i_bp_valid;
`endif

    modport master (
        output is_start, i_mode, i_step_count, is_step_req,
        output is_stop_pipe, is_done_send, is_abort,
`ifdef DEBUG_BREAKPOINT_EN
        output i_pc, i_bp_addr, i_bp_valid,
`endif
        input  os_step, os_start_send, os_done, o_clk_count,
        input  o_busy, o_timeout, o_state
    );

    modport slave (
        input  is_start, i_mode, i_step_count, is_step_req,
        input  is_stop_pipe, is_done_send, is_abort,
`ifdef DEBUG_BREAKPOINT_EN
        input  i_pc, i_bp_addr, i_bp_valid,
`endif
        output os_step, os_start_send, os_done, o_clk_count,
        output o_busy, o_timeout, o_state
    );

endinterface

// File: rtl/debug_cycle_counter.sv
// Saturating executed-cycle counter with clear, enable and equality compare.
module debug_cycle_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         hit
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != '1) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == limit);

endmodule

// File: rtl/debug_run_ctrl.sv
// Debugger run controller: continuous, single-step and N-step pipeline runs.
// Define DEBUG_BREAKPOINT_EN to add a PC breakpoint stop condition.
module debug_run_ctrl
    import debug_pkg::*;
#(
    parameter int unsigned CLK_CNT_W      = 32,
    parameter int unsigned STEP_CNT_W     = 16,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
`ifdef DEBUG_BREAKPOINT_EN
    , parameter int unsigned PC_W = 32
`endif
) (
    input logic             clk,
    input logic             rst,
    debug_run_ctrl_if.slave bus
);

    localparam logic [CLK_CNT_W-1:0] WD_LIMIT = CLK_CNT_W'(TIMEOUT_CYCLES);

    run_state_e            state;
    logic [1:0]            mode;
    logic [STEP_CNT_W-1:0] remaining;
    logic                  halted;
    logic                  timeout;
    logic [CLK_CNT_W-1:0]  count;
    logic                  cnt_hit;
    logic                  wd_hit;
    logic                  bp_hit;
    logic                  nstep;
    logic                  sstep;
    logic                  stop_cond;
    logic                  step;
    logic                  accept;

`ifdef DEBUG_BREAKPOINT_EN
    assign bp_hit = bus.i_bp_valid & (bus.i_pc == bus.i_bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    assign nstep     = (mode == MODE_NSTEP);
    assign sstep     = (mode == MODE_STEP);
    assign wd_hit    = (TIMEOUT_CYCLES != 0) & cnt_hit;
    assign stop_cond = bus.is_stop_pipe | bus.is_abort | wd_hit | bp_hit
                     | (nstep & (remaining == '0));
    assign accept    = (state == RUN_IDLE) & bus.is_start;

    // A single step is withheld when abort or a prior halt ends the session.
    assign step = ((state == RUN_RUN) & ~stop_cond)
                | ((state == RUN_STEP_WAIT) & bus.is_step_req
                   & ~bus.is_abort & ~halted);

    debug_cycle_counter #(.W(CLK_CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (step),
        .limit (WD_LIMIT),
        .count (count),
        .hit   (cnt_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN_IDLE;
            mode      <= MODE_CONT;
            remaining <= '0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (bus.is_stop_pipe | ((state == RUN_STEP_WAIT) & bp_hit))
                halted <= 1'b1;
            unique case (state)
                RUN_IDLE: begin
                    if (bus.is_start) begin
                        mode      <= bus.i_mode;
                        remaining <= bus.i_step_count;
                        halted    <= 1'b0;
                        timeout   <= 1'b0;
                        state     <= (bus.i_mode == MODE_STEP) ?
                                     RUN_STEP_WAIT : RUN_RUN;
                    end
                end
                RUN_RUN: begin
                    if (step & nstep)
                        remaining <= remaining - 1'b1;
                    if (stop_cond) begin
                        state <= RUN_SEND;
                        if (wd_hit)
                            timeout <= 1'b1;
                    end
                end
                RUN_STEP_WAIT: begin
                    if (bus.is_abort | halted)
                        state <= RUN_DONE;
                    else if (bus.is_step_req)
                        state <= RUN_SEND;
                end
                RUN_SEND: state <= RUN_WAIT_SEND;
                RUN_WAIT_SEND: begin
                    if (bus.is_done_send)
                        state <= (sstep & ~halted) ? RUN_STEP_WAIT : RUN_DONE;
                end
                RUN_DONE: state <= RUN_IDLE;
                default:  state <= RUN_IDLE;
            endcase
        end
    end

    assign bus.os_step       = step;
    assign bus.os_start_send = (state == RUN_SEND);
    assign bus.os_done       = (state == RUN_DONE);
    assign bus.o_clk_count   = count;
    assign bus.o_busy        = (state != RUN_IDLE);
    assign bus.o_timeout     = timeout;
    assign bus.o_state       = state;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Scoreboard bench for debug_run_ctrl: expected send/done events are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_debug_run_ctrl;
    import debug_pkg::*;

    typedef struct {
        bit          done;
        logic [31:0] cnt;
        int          steps;
        bit          to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   steps_acc = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    debug_run_ctrl_if bus ();

    debug_run_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef DEBUG_BREAKPOINT_EN
    assign bus.i_pc = {bus.o_clk_count[29:0], 2'b00};
`endif

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic push(input bit d, input int c, input int s, input bit t);
        exp_t e;
        e.done  = d;
        e.cnt   = c;
        e.steps = s;
        e.to    = t;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per send or done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            steps_acc = 0;
        end else begin
            if (bus.os_step)
                steps_acc++;
            if (bus.os_start_send || bus.os_done) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got send=%0b done=%0b, want none",
                             bus.os_start_send, bus.os_done);
                end else begin
                    e = q.pop_front();
                    if (bus.os_done !== e.done || bus.os_start_send !== !e.done ||
                        bus.o_clk_count !== e.cnt || steps_acc != e.steps ||
                        bus.o_timeout !== e.to) begin
                        fails++;
                        $display("FAIL sb_event: got done=%0b cnt=%0d steps=%0d to=%0b, want done=%0b cnt=%0d steps=%0d to=%0b",
                                 bus.os_done, bus.o_clk_count, steps_acc,
                                 bus.o_timeout, e.done, e.cnt, e.steps, e.to);
                    end
                end
                steps_acc = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ev(input bit done, input string name);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = done ? bus.os_done : bus.os_start_send;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s: got no pulse in 200 cycles, want pulse", name);
        end
    endtask

    task automatic start(input logic [1:0] m, input int n);
        bus.i_mode       = m;
        bus.i_step_count = 16'(n);
        bus.is_start     = 1'b1;
        tick();
        bus.is_start     = 1'b0;
    endtask

    task automatic serve_send(input int dly, input bit ab);
        wait_ev(1'b0, "wait_send");
        tick();
        if (ab)
            bus.is_abort = 1'b1;
        repeat (dly) tick();
        bus.is_abort = 1'b0;
        if (ab)
            chk("abort_ignored_wait_send", 32'(bus.o_state), 32'd4);
        bus.is_done_send = 1'b1;
        tick();
        bus.is_done_send = 1'b0;
    endtask

    task automatic finish(input string name, input int c, input bit t);
        wait_ev(1'b1, {name, "_done"});
        repeat (3) tick();
        chk({name, "_cnt_hold"}, bus.o_clk_count, 32'(c));
        chk({name, "_to_hold"}, 32'(bus.o_timeout), 32'(t));
        chk({name, "_idle"}, {29'd0, bus.o_state}, 32'd0);
    endtask

    initial begin
        bus.is_start     = 1'b0;
        bus.i_mode       = 2'b00;
        bus.i_step_count = '0;
        bus.is_step_req  = 1'b0;
        bus.is_stop_pipe = 1'b0;
        bus.is_done_send = 1'b0;
        bus.is_abort     = 1'b0;
`ifdef DEBUG_BREAKPOINT_EN
        bus.i_bp_addr    = '0;
        bus.i_bp_valid   = 1'b0;
`endif
        #12;
        chk("rst_state", {29'd0, bus.o_state}, 32'd0);
        chk("rst_outs", {26'd0, bus.os_step, bus.os_start_send, bus.os_done,
                         bus.o_busy, bus.o_timeout, 1'b0}, 32'd0);
        chk("rst_cnt", bus.o_clk_count, 32'd0);
        rst = 1'b1;
        tick();

        // Continuous: halt in the 10th run cycle gives 9 steps.
        push(0, 9, 9, 0);
        push(1, 9, 0, 0);
        start(MODE_CONT, 0);
        chk("cont_busy", 32'(bus.o_busy), 32'd1);
        repeat (9) tick();
        bus.is_stop_pipe = 1'b1;
        tick();
        bus.is_stop_pipe = 1'b0;
        serve_send(5, 0);
        finish("cont", 9, 0);

        // N-step budgets of 4 and 0; mode 11 also runs continuously.
        push(0, 4, 4, 0);
        push(1, 4, 0, 0);
        start(MODE_NSTEP, 4);
        serve_send(2, 0);
        finish("nstep4", 4, 0);
        push(0, 0, 0, 0);
        push(1, 0, 0, 0);
        start(MODE_NSTEP, 0);
        serve_send(1, 0);
        finish("nstep0", 0, 0);

        // Single-step: three requests, halt during the third.
        for (int i = 1; i <= 3; i++)
            push(0, i, 1, 0);
        push(1, 3, 0, 0);
        start(MODE_STEP, 0);
        for (int i = 1; i <= 3; i++) begin
            repeat (2) tick();
            chk("step_wait_state", {29'd0, bus.o_state}, 32'd2);
            bus.is_step_req = 1'b1;
            if (i == 3)
                bus.is_stop_pipe = 1'b1;
            tick();
            bus.is_step_req  = 1'b0;
            bus.is_stop_pipe = 1'b0;
            serve_send(3, 0);
        end
        finish("sstep", 3, 0);

        // Watchdog at 16 executed cycles; flag held until next start.
        push(0, 16, 16, 1);
        push(1, 16, 0, 1);
        start(2'b11, 0);
        serve_send(2, 0);
        finish("wdog", 16, 1);
        push(0, 5, 5, 0);
        push(1, 5, 0, 0);
        start(MODE_CONT, 0);
        chk("wdog_to_cleared", 32'(bus.o_timeout), 32'd0);
        chk("wdog_cnt_cleared", bus.o_clk_count, 32'd0);

        // Abort in RUN after 5 steps, then abort ignored in WAIT_SEND.
        repeat (5) tick();
        bus.is_abort = 1'b1;
        tick();
        bus.is_abort = 1'b0;
        serve_send(4, 1);
        finish("abort", 5, 0);

`ifdef DEBUG_BREAKPOINT_EN
        push(0, 8, 8, 0);
        push(1, 8, 0, 0);
        bus.i_bp_addr  = 32'h20;
        bus.i_bp_valid = 1'b1;
        start(MODE_CONT, 0);
        serve_send(2, 0);
        bus.i_bp_valid = 1'b0;
        finish("bp", 8, 0);
`endif

        // Asynchronous reset in the middle of a run.
        start(MODE_CONT, 0);
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", {29'd0, bus.o_state}, 32'd0);
        chk("arst_outs", {27'd0, bus.os_step, bus.os_start_send, bus.os_done,
                          bus.o_busy, bus.o_timeout}, 32'd0);
        chk("arst_cnt", bus.o_clk_count, 32'd0);
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("arst_stays_idle", {29'd0, bus.o_state}, 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
